// File: rtl/pipelined_carry_adder.sv
// N-bit adder split into STAGES ripple-carry chunks with registered carries and a valid/ready stall.
// Define PIPE_ADD_OVF_EN to add the signed-overflow output ovf.
module pipelined_carry_adder #(
  parameter int unsigned N      = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  generate
    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_carry_adder: N must be a multiple of STAGES and 1 <= STAGES <= N");
    end
  endgenerate

  localparam int unsigned W = N / STAGES;

  // Register k holds the beat after chunk k has been added; register STAGES-1 is the output.
  logic         vld_q [STAGES];
  logic         vld_d [STAGES];
  logic [N-1:0] a_q   [STAGES];
  logic [N-1:0] a_d   [STAGES];
  logic [N-1:0] b_q   [STAGES];
  logic [N-1:0] b_d   [STAGES];
  logic [N-1:0] s_q   [STAGES];
  logic [N-1:0] s_d   [STAGES];
  logic         c_q   [STAGES];
  logic         c_d   [STAGES];

  logic         vin_s [STAGES];
  logic [N-1:0] ain_s [STAGES];
  logic [N-1:0] bin_s [STAGES];
  logic [N-1:0] sin_s [STAGES];
  logic         cin_s [STAGES];

  logic         adv;
  logic [N-1:0] s_tmp;
  logic         c_tmp;

`ifdef PIPE_ADD_OVF_EN
  logic         c_msb;
  logic         ovf_q;
  logic         ovf_d;
`endif

  always_comb begin
    adv = !vld_q[STAGES-1] || out_ready;

    vin_s[0] = in_valid;
    ain_s[0] = a;
    bin_s[0] = b;
    sin_s[0] = '0;
    cin_s[0] = cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      vin_s[k] = vld_q[k-1];
      ain_s[k] = a_q[k-1];
      bin_s[k] = b_q[k-1];
      sin_s[k] = s_q[k-1];
      cin_s[k] = c_q[k-1];
    end

    s_tmp = '0;
    c_tmp = 1'b0;
`ifdef PIPE_ADD_OVF_EN
    c_msb = 1'b0;
`endif
    for (int unsigned k = 0; k < STAGES; k++) begin
      s_tmp = sin_s[k];
      c_tmp = cin_s[k];
      for (int unsigned i = 0; i < W; i++) begin
`ifdef PIPE_ADD_OVF_EN
        if (k*W + i == N - 1) c_msb = c_tmp;
`endif
        s_tmp[k*W+i] = ain_s[k][k*W+i] ^ bin_s[k][k*W+i] ^ c_tmp;
        c_tmp = (ain_s[k][k*W+i] & bin_s[k][k*W+i]) |
                (ain_s[k][k*W+i] & c_tmp) |
                (bin_s[k][k*W+i] & c_tmp);
      end
      // Bubbles carry zero data so the output reads 0 whenever out_valid is low.
      vld_d[k] = adv ? vin_s[k] : vld_q[k];
      a_d[k]   = adv ? (vin_s[k] ? ain_s[k] : '0) : a_q[k];
      b_d[k]   = adv ? (vin_s[k] ? bin_s[k] : '0) : b_q[k];
      s_d[k]   = adv ? (vin_s[k] ? s_tmp : '0) : s_q[k];
      c_d[k]   = adv ? (vin_s[k] & c_tmp) : c_q[k];
    end

`ifdef PIPE_ADD_OVF_EN
    ovf_d = adv ? (vin_s[STAGES-1] & (c_msb ^ c_tmp)) : ovf_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
`ifdef PIPE_ADD_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
      end
`ifdef PIPE_ADD_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef PIPE_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised successor to the single-cycle combinational adder: an N-bit add split into STAGES equal chunks.
- Each chunk is a ripple-carry segment; the carry is registered between stages, which shortens the critical path to N/STAGES bit-cells.
- Valid/ready handshake on both sides with full-pipeline stall.
- Sits in datapaths needing wide adds at high clock rate, with one result per cycle at latency STAGES.

Parameters:
- N, 16, operand/sum width in bits; must be a multiple of STAGES (elaboration-time assertion otherwise).
- STAGES, 4, number of pipeline stages/chunks; 1 <= STAGES <= N; chunk width W = N/STAGES.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  N  a+b+cin, low N bits.
- cout  output  1  carry out of bit N-1.

Behaviour:
- Clocking: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all stage valid bits=0, out_valid=0, sum=0, cout=0, internal carry/operand registers=0. in_ready=1 during and after reset (combinational from state).
- Reset mid-operation: all in-flight beats are discarded; no result is emitted for them.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv. Accept = in_valid && in_ready.
- On adv, every stage register shifts one stage. Stage 0 captures the new beat (valid=in_valid) or a bubble. The output register takes the last stage.
- When adv=0, all registers hold, including out_valid/sum/cout.
- Stage k (0-based) adds chunk k: a[kW+W-1:kW] + b[...] + carry_in. carry_in is cin for k=0 and the registered carry from stage k-1 otherwise.
- Chunk ripple per bit: s=a^b^c; c'=ab|ac|bc.
- Operand skew: chunks k>0 travel through k delay registers alongside the pipeline. Completed low chunks travel forward to the output with the beat.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+STAGES when there are no stalls. Each stall cycle adds exactly one cycle.
- Throughput: 1 beat/cycle when out_ready is held 1. Bubbles are not collapsed; they pass through as invalid slots.
- Ordering: strictly in order, no drops, no duplicates. The output holds stable while out_valid && !out_ready.
- Simultaneous accept and output handshake in the same cycle is legal and is the steady state.
- STAGES=1: degenerates to a registered full adder, latency 1.
- Wrap-around: sum is modulo 2^N; cout reports the carry. No other flags unless the optional feature is enabled.
- Data registers may be left unreset only if out_valid gating is kept. The required reset values above still apply to the outputs.

Optional Feature:
- Macro PIPE_ADD_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), the two's-complement signed overflow of the beat.
  - ovf = carry into bit N-1 XOR carry out of bit N-1, computed in the last stage.
  - Aligned with sum; holds under stall like sum.
- Undefined: no ovf port and no extra logic; all other behaviour is identical.

Test Plan (N=16, STAGES=4 unless stated):
- Reset, then a=0xFFFF, b=0x0001, cin=0, single beat, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0000, cout=1. The carry must ripple through all 4 stages.
- Back-to-back beats (0x1234+0x1111, 0x00FF+0x0001 cin=1, 0x8000+0x8000), out_ready=1 -> consecutive outputs 0x2345/0, 0x0101/0, 0x0000/1 on 3 consecutive cycles, in order.
- Backpressure: stream 8 beats with out_ready low for 3 cycles mid-stream -> in_ready=0 while the output is stalled, the held output is unchanged, all 8 results correct and in order.
- Reset mid-flight: 3 beats accepted, rst=1 for 1 cycle -> out_valid=0, sum=0, cout=0; no result for the discarded beats ever appears.
- Random: 10k random a/b/cin with random in_valid/out_ready, and N=8 with STAGES=1/2/8 -> the scoreboard matches a+b+cin modulo 2^N plus cout, latency exactly STAGES plus stall cycles.
- With PIPE_ADD_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0xFFFF+0x0001 -> ovf=0, cout=1.
